// File: rtl/neuro_pkg.sv
// neuro_pkg: shared chain constants and loader state encoding for the neuron config path.
package neuro_pkg;
    localparam int BITS_PER_NEURON = 17;
    localparam int W_WEIGHT = 3;
    localparam int W_TSEL = 3;
    localparam int W_U = 5;
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} ld_state_e;
endpackage

// File: rtl/neuro_rb_deser.sv
// neuro_rb_deser: packs returning chain bits MSB-first into bytes; a short final byte is left-aligned.
module neuro_rb_deser (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       bit_in,
    input  logic       last,
    output logic [7:0] rb_byte,
    output logic       rb_valid
);
    logic [6:0] sh_q, sh_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] rb_byte_q, rb_byte_d, full;
    logic       rb_valid_q, rb_valid_d;
    always_comb begin
        full = {sh_q, bit_in};
        rb_valid_d = en && (cnt_q == 3'd7 || last);
        sh_d = en ? full[6:0] : sh_q;
        cnt_d = rb_valid_d ? 3'd0 : (en ? cnt_q + 3'd1 : cnt_q);
        // shifting out the unfilled positions drops stale bits and zero-pads the tail
        rb_byte_d = rb_valid_d ? full << (3'd7 - cnt_q) : rb_byte_q;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_q <= '0;
            cnt_q <= '0;
            rb_byte_q <= '0;
            rb_valid_q <= 1'b0;
        end else begin
            sh_q <= sh_d;
            cnt_q <= cnt_d;
            rb_byte_q <= rb_byte_d;
            rb_valid_q <= rb_valid_d;
        end
    end
    assign rb_byte = rb_byte_q;
    assign rb_valid = rb_valid_q;
endmodule

// File: rtl/neuro_cfg_loader.sv
// neuro_cfg_loader: byte-to-serial loader for the neuron config chain.
// Readback deserialiser is built only when NEURO_CFG_READBACK_EN is defined.
module neuro_cfg_loader
    import neuro_pkg::*;
#(
    parameter int NEURONS = 1,
    parameter int CHAIN_LEN = NEURONS * BITS_PER_NEURON
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic       conf_en,
    output logic       bs_in,
    input  logic       bs_out,
    output logic       busy,
    output logic       done,
    output logic [7:0] rb_byte,
    output logic       rb_valid
);
    localparam int CW = $clog2(CHAIN_LEN + 1);
    ld_state_e   state_q, state_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [CW-1:0] bit_cnt_q, bit_cnt_d;
    logic [2:0]  bib_q, bib_d;
    logic        byte_ready_q, conf_en_q, bs_in_q, busy_q, done_q;
    logic        last_bit;
    // testing before the increment keeps the counter within CHAIN_LEN
    assign last_bit = bit_cnt_q == CW'(CHAIN_LEN - 1);
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        bit_cnt_d = bit_cnt_q;
        bib_d = bib_q;
        case (state_q)
            IDLE: begin
                bit_cnt_d = '0;
                bib_d = '0;
                state_d = start ? LOAD : IDLE;
            end
            LOAD: begin
                shreg_d = byte_valid ? byte_in : shreg_q;
                state_d = byte_valid ? SHIFT : LOAD;
            end
            SHIFT: begin
                shreg_d = {shreg_q[6:0], 1'b0};
                bit_cnt_d = bit_cnt_q + CW'(1);
                bib_d = bib_q + 3'd1;
                state_d = last_bit ? DONE : (bib_q == 3'd7 ? LOAD : SHIFT);
            end
            default: state_d = IDLE;
        endcase
    end
    // outputs are registered from next-state so they align with the state they describe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            bit_cnt_q <= '0;
            bib_q <= '0;
            byte_ready_q <= 1'b0;
            conf_en_q <= 1'b0;
            bs_in_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            bib_q <= bib_d;
            byte_ready_q <= state_d == LOAD;
            conf_en_q <= state_d == SHIFT;
            bs_in_q <= state_d == SHIFT && shreg_d[7];
            busy_q <= state_d != IDLE;
            done_q <= state_d == DONE;
        end
    end
    assign byte_ready = byte_ready_q;
    assign conf_en = conf_en_q;
    assign bs_in = bs_in_q;
    assign busy = busy_q;
    assign done = done_q;
`ifdef NEURO_CFG_READBACK_EN
    neuro_rb_deser u_rb (
        .clk      (clk),
        .reset    (reset),
        .en       (conf_en_q),
        .bit_in   (bs_out),
        .last     (conf_en_q && last_bit),
        .rb_byte  (rb_byte),
        .rb_valid (rb_valid)
    );
`else
    logic unused_bs_out;
    assign unused_bs_out = bs_out;
    assign rb_byte = 8'h00;
    assign rb_valid = 1'b0;
`endif
endmodule

// File: tb/tb_neuro_cfg_loader.sv
// tb_neuro_cfg_loader: scoreboard bench for the config loader with a 17-bit chain model and a 34-bit instance.
module tb_neuro_cfg_loader;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic start = 1'b0, byte_valid = 1'b0;
    logic [7:0] byte_in = 8'h00;
    logic byte_ready, conf_en, bs_in, bs_out, busy, done, rb_valid;
    logic [7:0] rb_byte;

    logic start2 = 1'b0, byte_valid2 = 1'b0;
    logic [7:0] byte_in2 = 8'h00;
    logic byte_ready2, conf_en2, bs_in2, busy2, done2, rb_valid2;
    logic [7:0] rb_byte2;

    neuro_cfg_loader dut (
        .clk(clk), .reset(reset), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .conf_en(conf_en), .bs_in(bs_in), .bs_out(bs_out),
        .busy(busy), .done(done), .rb_byte(rb_byte), .rb_valid(rb_valid)
    );

    neuro_cfg_loader #(.NEURONS(2)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .byte_in(byte_in2), .byte_valid(byte_valid2),
        .byte_ready(byte_ready2), .conf_en(conf_en2), .bs_in(bs_in2), .bs_out(1'b0),
        .busy(busy2), .done(done2), .rb_byte(rb_byte2), .rb_valid(rb_valid2)
    );

    int vectors = 0, miscompares = 0, cyc = 0;
    int nbits, ndone, nhs, nrb, done_cyc, last_cyc;
    int nbits2, ndone2, nhs2, done2_cyc, last2_cyc;
    bit exp_q[$], exp2_q[$];
    logic [7:0] rb_exp[$];
    bit rb_chk = 1'b0, pd = 1'b0, eb, eb2;
    logic [7:0] eby;
    logic [16:0] chain = '0;
    assign bs_out = chain[16];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (conf_en) chain <= {chain[15:0], bs_in};
    end

    always @(negedge clk) if (!reset) begin
        vectors++;
        if (conf_en) begin
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL bs_in: got %b with no bit expected", bs_in);
            end else begin
                eb = exp_q.pop_front();
                if (bs_in !== eb) begin
                    miscompares++;
                    $display("FAIL bs_in: got %b want %b (bit %0d)", bs_in, eb, nbits);
                end
            end
            nbits++;
            last_cyc = cyc;
        end else if (bs_in !== 1'b0) begin
            miscompares++;
            $display("FAIL bs_idle: got %b want 0", bs_in);
        end
        vectors++;
        if (conf_en && byte_ready) begin
            miscompares++;
            $display("FAIL ready_vs_en: byte_ready=1 and conf_en=1 together, want exclusive");
        end
        if (pd) begin
            vectors++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                miscompares++;
                $display("FAIL after_done: busy=%b done=%b want 0 0", busy, done);
            end
        end
        pd = done;
        if (done) begin
            ndone++;
            done_cyc = cyc;
        end
        if (byte_valid && byte_ready) nhs++;
`ifdef NEURO_CFG_READBACK_EN
        if (rb_valid && rb_chk) begin
            nrb++;
            vectors++;
            eby = rb_exp.size() > 0 ? rb_exp.pop_front() : 8'hxx;
            if (rb_byte !== eby) begin
                miscompares++;
                $display("FAIL rb_byte: got %h want %h", rb_byte, eby);
            end
        end
`else
        vectors++;
        if (rb_valid !== 1'b0 || rb_byte !== 8'h00) begin
            miscompares++;
            $display("FAIL rb_off: rb_valid=%b rb_byte=%h want 0 00", rb_valid, rb_byte);
        end
`endif
    end

    always @(negedge clk) if (!reset) begin
        vectors++;
        if (conf_en2) begin
            eb2 = exp2_q.size() > 0 ? exp2_q.pop_front() : 1'bx;
            if (bs_in2 !== eb2) begin
                miscompares++;
                $display("FAIL bs_in2: got %b want %b (bit %0d)", bs_in2, eb2, nbits2);
            end
            nbits2++;
            last2_cyc = cyc;
        end else if (bs_in2 !== 1'b0) begin
            miscompares++;
            $display("FAIL bs_idle2: got %b want 0", bs_in2);
        end
        if (done2) begin
            ndone2++;
            done2_cyc = cyc;
        end
        if (byte_valid2 && byte_ready2) nhs2++;
    end

    task automatic push_bits(input logic [7:0] b, input int n, input bit second);
        for (int i = 7; i > 7 - n; i--)
            if (second) exp2_q.push_back(b[i]);
            else exp_q.push_back(b[i]);
    endtask

    task automatic wait_hs();
        bit ok = 1'b0;
        for (int k = 0; k < 64 && !ok; k++) begin
            @(negedge clk);
            ok = byte_valid && byte_ready;
            @(posedge clk);
            #1;
        end
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL handshake: no transfer within 64 cycles, want one");
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic run_load(input logic [7:0] b0, b1, b2, input int gap, input bit mid_start);
        logic [7:0] bs [3];
        int sc;
        bs = '{b0, b1, b2};
        nbits = 0; ndone = 0; nhs = 0; done_cyc = -1; last_cyc = -9;
        push_bits(b0, 8, 0); push_bits(b1, 8, 0); push_bits(b2, 1, 0);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        sc = cyc;
        vectors++;
        if (busy !== 1'b1 || byte_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL start_resp: busy=%b byte_ready=%b want 1 1", busy, byte_ready);
        end
        byte_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0 && gap > 0) begin
                for (int k = 0; k < 32 && !byte_ready; k++) @(negedge clk);
                repeat (gap) @(posedge clk);
                #1 byte_valid = 1'b1;
            end
            byte_in = bs[i];
            wait_hs();
            byte_valid = gap == 0;
            if (mid_start && i == 0) begin
                @(posedge clk);
                #1 start = 1'b1;
                @(posedge clk);
                #1 start = 1'b0;
            end
        end
        for (int k = 0; k < 64 && ndone == 0; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        byte_valid = 1'b0;
        check_int("bit_count", nbits, 17);
        check_int("done_count", ndone, 1);
        check_int("handshakes", nhs, 3);
        check_int("bits_left", exp_q.size(), 0);
        check_int("load_cycles", done_cyc - sc, 20 + 2 * gap);
        check_int("done_lag", done_cyc - last_cyc, 1);
        check_int("busy_end", int'(busy), 0);
    endtask

    task automatic test_reset();
        #2;
        vectors++;
        if ({byte_ready, conf_en, bs_in, busy, done, rb_valid} !== 6'b0 || rb_byte !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_vals: rdy=%b en=%b bs=%b busy=%b done=%b rbv=%b rb=%h want all 0",
                     byte_ready, conf_en, bs_in, busy, done, rb_valid, rb_byte);
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_int("idle_busy", int'(busy), 0);
        check_int("idle_ready", int'(byte_ready), 0);
    endtask

    task automatic test_basic();
        run_load(8'hA5, 8'h3C, 8'h80, 0, 0);
    endtask

    task automatic test_gap();
        run_load(8'hA5, 8'h3C, 8'h80, 5, 0);
    endtask

    task automatic test_start_mid();
        run_load(8'h5A, 8'hC3, 8'h7F, 0, 1);
    endtask

    task automatic test_reset_mid();
        nbits = 0;
        exp_q.delete();
        push_bits(8'hA5, 8, 0); push_bits(8'h3C, 8, 0); push_bits(8'h80, 1, 0);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        byte_valid = 1'b1;
        byte_in = 8'hA5;
        wait_hs();
        byte_in = 8'h3C;
        for (int k = 0; k < 64 && nbits < 10; k++) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        vectors++;
        if (conf_en !== 1'b0 || busy !== 1'b0 || byte_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: conf_en=%b busy=%b byte_ready=%b want 0 0 0", conf_en, busy, byte_ready);
        end
        check_int("bits_before_reset", nbits, 10);
        byte_valid = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        run_load(8'hA5, 8'h3C, 8'h80, 0, 0);
    endtask

    task automatic test_back_to_back();
        run_load(8'hA5, 8'h3C, 8'h80, 0, 0);
`ifdef NEURO_CFG_READBACK_EN
        rb_exp = '{8'hA5, 8'h3C, 8'h80};
        nrb = 0;
        rb_chk = 1'b1;
`endif
        run_load(8'hFF, 8'hFF, 8'hFF, 0, 0);
`ifdef NEURO_CFG_READBACK_EN
        rb_chk = 1'b0;
        check_int("rb_pulses", nrb, 3);
        check_int("rb_left", rb_exp.size(), 0);
`endif
    endtask

    task automatic test_two_neurons();
        logic [7:0] bs [5];
        bit ok;
        int sc;
        bs = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hC0};
        nbits2 = 0; ndone2 = 0; nhs2 = 0; done2_cyc = -1; last2_cyc = -9;
        for (int i = 0; i < 5; i++) push_bits(bs[i], i < 4 ? 8 : 2, 1);
        start2 = 1'b1;
        @(posedge clk);
        #1 start2 = 1'b0;
        sc = cyc;
        byte_valid2 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            byte_in2 = bs[i];
            ok = 1'b0;
            for (int k = 0; k < 64 && !ok; k++) begin
                @(negedge clk);
                ok = byte_valid2 && byte_ready2;
                @(posedge clk);
                #1;
            end
        end
        byte_valid2 = 1'b0;
        repeat (6) @(negedge clk);
        check_int("n2_bits", nbits2, 34);
        check_int("n2_handshakes", nhs2, 5);
        check_int("n2_done_count", ndone2, 1);
        check_int("n2_done_lag", done2_cyc - last2_cyc, 1);
        check_int("n2_load_cycles", done2_cyc - sc, 39);
        check_int("n2_bits_left", exp2_q.size(), 0);
        check_int("n2_busy_end", int'(busy2), 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gap();
        test_start_mid();
        test_reset_mid();
        test_back_to_back();
        test_two_neurons();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/neuro_cfg_loader.md
# neuro_cfg_loader

Byte-wide configuration loader sitting directly upstream of the neuron array's configuration shift chain. Accepts configuration bytes over a valid/ready handshake and serialises exactly `CHAIN_LEN` bits MSB-first onto the chain's `bs_in`. It drives `conf_en` high only on cycles where a bit actually moves. Optionally deserialises the chain's `bs_out` into readback bytes so the previous configuration can be checked.

## Interface
- `NEURONS`, default 1: number of neurons in the chain.
- `BITS_PER_NEURON`, default 17 (package constant): chain bits per neuron (wA, wB, wC, tSel, U = 3+3+3+3+5).
- `CHAIN_LEN`, default `NEURONS*BITS_PER_NEURON`: total bits shifted per load; ≥1.

Ports:
- `clk` in 1: clock; all state on rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: begin a load; sampled in IDLE only.
- `byte_in` in 8: configuration byte; bit 7 shifted first.
- `byte_valid` in 1: `byte_in` valid.
- `byte_ready` out 1: loader accepts a byte this cycle.
- `conf_en` out 1: chain shift enable.
- `bs_in` out 1: serial bit to chain.
- `bs_out` in 1: serial bit returning from chain end.
- `busy` out 1: high in any state but IDLE.
- `done` out 1: one-cycle pulse after the final bit.
- `rb_byte` out 8: readback byte.
- `rb_valid` out 1: one-cycle pulse, `rb_byte` valid.

## Operation
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE: `start`=1 → LOAD. The bit counter clears to 0.
- LOAD: `byte_ready`=1. A transfer occurs on `byte_valid && byte_ready`; it latches the byte into an 8-bit shift register and moves to SHIFT. If no byte arrives, the loader stays in LOAD with `conf_en`=0, so the chain holds its state.
- SHIFT:
  - `conf_en`=1 and `bs_in`=shreg[7].
  - Each cycle: shreg shifts left, the bit counter increments, and the bit-in-byte counter increments.
  - When the bit counter reaches `CHAIN_LEN`, go to DONE.
  - Otherwise, after 8 bits of the current byte, go to LOAD.
  - Leftover low bits of the last byte are discarded. The number of bytes needed is ceil(CHAIN_LEN/8).
- DONE: `done`=1 for one cycle, then IDLE.
- `start` outside IDLE is ignored. `start` and `byte_valid` together in IDLE: no byte is accepted that cycle.
- Bit counter width is $clog2(CHAIN_LEN+1). It never wraps, because the terminal compare precedes the increment.
- `bs_in` = 0 whenever `conf_en` = 0.
- Reset asserted mid-load: immediate return to IDLE with `conf_en`=0. The partial chain contents are left as-is. The next `start` reloads all `CHAIN_LEN` bits.

## Timing
- Reset values:
  - `byte_ready`=0, `conf_en`=0, `bs_in`=0, `busy`=0, `done`=0.
  - `rb_byte`=0x00, `rb_valid`=0.
- `start` at edge n → `busy`=1 and `byte_ready`=1 from cycle n+1.
- Byte accepted at edge t → `conf_en`=1 for cycles t+1..t+8, or fewer for the final byte. `byte_ready`=0 during those cycles.
- Minimum 9 cycles per byte.
- Final bit on cycle f → `done`=1 on cycle f+1 and `busy`=0 on f+2.
- All outputs are registered.

## Configuration
- `NEURO_CFG_READBACK_EN` defined:
  - On every `conf_en` cycle, `bs_out` is sampled and shifted MSB-first into the readback byte.
  - `rb_valid` pulses on the cycle after the 8th bit of each byte.
  - It also pulses after the final chain bit; a partial final byte is left-aligned and zero-padded.
  - Readback order equals the load byte order of the previous configuration.
- Macro undefined: no readback logic; `rb_byte`=0x00 and `rb_valid`=0 constantly.

## Structure
- `neuro_pkg`: `BITS_PER_NEURON`=17, loader state enum (IDLE/LOAD/SHIFT/DONE), per-field widths (`W_WEIGHT`=3, `W_TSEL`=3, `W_U`=5).
- Sub-module `neuro_rb_deser`: the readback deserialiser (inputs `clk`, `reset`, `en`, `bit`, `last`; outputs `rb_byte`, `rb_valid`). It is instantiated only under `NEURO_CFG_READBACK_EN`.

## Test plan
- NEURONS=1; start, bytes 0xA5, 0x3C, 0x80 with `byte_valid` always high → `bs_in` over 17 `conf_en` cycles = 1010_0101_0011_1100_1. `done` pulses once; 3 byte handshakes total.
- Same load with `byte_valid` low for 5 cycles between bytes → `conf_en` low exactly during the gap. Bit sequence unchanged.
- Two back-to-back loads (0xA5, 0x3C, 0x80 then 0xFF, 0xFF, 0xFF) against a chain model, READBACK_EN → `rb_byte` 0xA5, 0x3C, 0x80 over three `rb_valid` pulses during the second load.
- `start` pulsed during SHIFT → ignored; exactly 17 bits shifted and one `done`.
- `reset` asserted after the 10th bit → `conf_en`, `busy`, `byte_ready` = 0 asynchronously. A subsequent full load shifts 17 bits from the first byte.
- NEURONS=2 (CHAIN_LEN=34) → 5 bytes accepted. Only the top 2 bits of byte 5 are shifted; `done` comes 1 cycle after the 34th `conf_en` cycle.
